// File: rtl/sdram_wr_arb_pkg.sv
// Shared types and field layout for the SDRAM write arbiter and its FIFO.
// The entry layout matches the controller's {mask, addr, data} decode.
package sdram_wr_arb_pkg;

  localparam int ENTRY_W = 25;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;

  localparam int MASK_BIT = 24;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  typedef struct packed {
    logic              mask;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  function automatic wr_entry_t pack_entry(input logic mask,
                                           input logic [ADDR_W-1:0] addr,
                                           input logic [DATA_W-1:0] data);
    wr_entry_t e;
    e.mask = mask;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/sdram_wr_fifo.sv
// Synchronous FIFO with a registered, non-show-ahead read port.
// Tracks occupancy for full/empty/almost-full and latches a sticky underflow flag.
module sdram_wr_fifo
  import sdram_wr_arb_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = DEPTH - 2,
  parameter int W         = ENTRY_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full,
  output logic         afull,
  output logic         underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0]   AFULL_C = (PW+1)'(AFULL_LVL);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign afull   = (count >= AFULL_C);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage array is left unreset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      underflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (pop && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_wr_arb.sv
// Round-robin arbiter merging CPU (port 0) and loader (port 1) byte writes into the SDRAM write FIFO.
// Optional per-port and stall statistics are enabled by defining SDRAM_WR_ARB_STATS_EN.
module sdram_wr_arb
  import sdram_wr_arb_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_req0_valid,
  input  logic [ADDR_W-1:0]  i_req0_addr,
  input  logic [DATA_W-1:0]  i_req0_data,
  input  logic               i_req0_mask,
  input  logic               i_req1_valid,
  input  logic [ADDR_W-1:0]  i_req1_addr,
  input  logic [DATA_W-1:0]  i_req1_data,
  input  logic               i_req1_mask,
  output logic               o_req0_ready,
  output logic               o_req1_ready,
  output logic               o_fifo_empty,
  output logic [ENTRY_W-1:0] o_fifo_data,
  input  logic               i_fifo_read,
  output logic               o_afull,
`ifdef SDRAM_WR_ARB_STATS_EN
  output logic [15:0]        o_stat_cnt0,
  output logic [15:0]        o_stat_cnt1,
  output logic [15:0]        o_stat_stall,
`endif
  output logic               o_underflow
);

  port_t     last_grant;
  port_t     next_grant;
  logic      grant0;
  logic      grant1;
  logic      full;
  logic      push;
  wr_entry_t push_entry;

  // Alternate on a tie: the port that did not win last time gets the grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case ({i_req1_valid, i_req0_valid})
      2'b01: grant0 = 1'b1;
      2'b10: grant1 = 1'b1;
      2'b11: begin
        if (last_grant == PORT1) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end
      default: begin
        grant0 = 1'b0;
        grant1 = 1'b0;
      end
    endcase
  end

  assign o_req0_ready = grant0 & ~full & ~i_reset;
  assign o_req1_ready = grant1 & ~full & ~i_reset;
  assign push         = o_req0_ready | o_req1_ready;

  always_comb begin
    push_entry = pack_entry(i_req0_mask, i_req0_addr, i_req0_data);
    next_grant = last_grant;
    if (o_req1_ready) begin
      push_entry = pack_entry(i_req1_mask, i_req1_addr, i_req1_data);
      next_grant = PORT1;
    end else if (o_req0_ready) begin
      next_grant = PORT0;
    end else begin
      next_grant = last_grant;
    end
  end

  // Reset to PORT1 so port 0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_grant <= PORT1;
    end else begin
      last_grant <= next_grant;
    end
  end

  sdram_wr_fifo #(
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL),
    .W         (ENTRY_W)
  ) u_fifo (
    .clk       (i_clk),
    .reset     (i_reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (i_fifo_read),
    .rd_data   (o_fifo_data),
    .empty     (o_fifo_empty),
    .full      (full),
    .afull     (o_afull),
    .underflow (o_underflow)
  );

`ifdef SDRAM_WR_ARB_STATS_EN
  logic stall;
  assign stall = (i_req0_valid & ~o_req0_ready) | (i_req1_valid & ~o_req1_ready);

  // Saturating counters: accepted writes per port and requester stall cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stat_cnt0  <= 16'd0;
      o_stat_cnt1  <= 16'd0;
      o_stat_stall <= 16'd0;
    end else begin
      if (o_req0_ready) begin
        o_stat_cnt0 <= sat_inc16(o_stat_cnt0);
      end
      if (o_req1_ready) begin
        o_stat_cnt1 <= sat_inc16(o_stat_cnt1);
      end
      if (stall) begin
        o_stat_stall <= sat_inc16(o_stat_stall);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sdram_wr_arb.sv
// Directed self-checking bench for sdram_wr_arb (DEPTH=8, AFULL_LVL=6).
// A small queue model tracks expected grants, occupancy and read data.
module tb_sdram_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, m0, m1, rd;
  logic [15:0] a0, a1;
  logic [7:0]  d0, d1;
  logic        r0, r1, empty, afull, uf;
  logic [24:0] data;
`ifdef SDRAM_WR_ARB_STATS_EN
  logic [15:0] sc0, sc1, ss;
`endif

  always #5 clk = ~clk;

  sdram_wr_arb #(.DEPTH(8), .AFULL_LVL(6)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req0_valid (v0),
    .i_req0_addr  (a0),
    .i_req0_data  (d0),
    .i_req0_mask  (m0),
    .i_req1_valid (v1),
    .i_req1_addr  (a1),
    .i_req1_data  (d1),
    .i_req1_mask  (m1),
    .o_req0_ready (r0),
    .o_req1_ready (r1),
    .o_fifo_empty (empty),
    .o_fifo_data  (data),
    .i_fifo_read  (rd),
    .o_afull      (afull),
`ifdef SDRAM_WR_ARB_STATS_EN
    .o_stat_cnt0  (sc0),
    .o_stat_cnt1  (sc1),
    .o_stat_stall (ss),
`endif
    .o_underflow  (uf)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          mcount;
  bit          mlg;
  logic [24:0] mdata;
  bit          muf;
  logic [24:0] q[$];
  int          r1_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] ent(input logic m, input logic [15:0] a, input logic [7:0] d);
    return {m, a, d};
  endfunction

  // One clock: check combinational outputs, take the edge, update the model, check registered outputs.
  task automatic cycle(input logic read_en);
    bit          er0, er1;
    logic [24:0] pushed;
    rd = read_en;
    #1;
    er0 = v0 && (!v1 || mlg) && (mcount < 8);
    er1 = v1 && (!v0 || !mlg) && (mcount < 8);
    check("ready0", 32'(r0), 32'(er0));
    check("ready1", 32'(r1), 32'(er1));
    check("empty", 32'(empty), 32'(mcount == 0));
    check("afull", 32'(afull), 32'(mcount >= 6));
    if (r1) r1_seen++;
    pushed = er1 ? ent(m1, a1, d1) : ent(m0, a0, d0);
    @(posedge clk);
    #1;
    if (read_en) begin
      if (mcount > 0) begin
        mdata = q.pop_front();
        mcount--;
      end else begin
        muf = 1'b1;
      end
    end
    if (er0 || er1) begin
      q.push_back(pushed);
      mcount++;
      mlg = er1;
    end
    if (er0) begin
      a0 = a0 + 16'h0101;
      d0 = d0 + 8'h11;
    end
    if (er1) begin
      a1 = a1 + 16'h0203;
      d1 = d1 + 8'h07;
      m1 = ~m1;
    end
    check("data", 32'(data), 32'(mdata));
    check("underflow", 32'(uf), 32'(muf));
    rd = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    rd  = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_ready0", 32'(r0), 32'd0);
      check("rst_ready1", 32'(r1), 32'd0);
      @(posedge clk);
      #1;
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_data", 32'(data), 32'd0);
      check("rst_underflow", 32'(uf), 32'd0);
      check("rst_afull", 32'(afull), 32'd0);
    end
    rst    = 1'b0;
    mcount = 0;
    mlg    = 1'b1;
    mdata  = 25'd0;
    muf    = 1'b0;
    q.delete();
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0;
    v0 = 1'b1; a0 = 16'h1111; d0 = 8'h22; m0 = 1'b1;
    v1 = 1'b1; a1 = 16'h2222; d1 = 8'h33; m1 = 1'b0;
    r1_seen = 0;
    @(posedge clk);
    #1;

    // Reset with both valids high; port 0 wins the first tie.
    do_reset(3);
    #1;
    check("t1_first_grant", 32'({r1, r0}), 32'h1);
    cycle(1'b0);
    v0 = 1'b0; v1 = 1'b0;
    cycle(1'b1);
    check("t1_data", 32'(data), 32'h0111_1122);
    cycle(1'b0);

    // Single write from port 0, then one read pulse.
    v0 = 1'b1; a0 = 16'h8123; d0 = 8'h5A; m0 = 1'b0;
    cycle(1'b0);
    v0 = 1'b0;
    cycle(1'b0);
    cycle(1'b1);
    check("t2_data", 32'(data), 32'h0081_235A);
    check("t2_empty", 32'(empty), 32'd1);
    cycle(1'b0);

    // Fairness: both valid for 8 pushes, grants alternate starting with port 0.
    do_reset(2);
    v0 = 1'b1; a0 = 16'h0400; d0 = 8'h01; m0 = 1'b0;
    v1 = 1'b1; a1 = 16'h0800; d1 = 8'h80; m1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t3_grant", 32'({r1, r0}), (i % 2 == 0) ? 32'h1 : 32'h2);
      cycle(1'b0);
    end
    cycle(1'b0);
    v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 8; i++) cycle(1'b1);
    cycle(1'b0);

    // Full: port 1 streams 10 requests with no reads; only 8 fit.
    v1 = 1'b1; a1 = 16'hC000; d1 = 8'h10; m1 = 1'b0;
    r1_seen = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0);
    check("t4_accepted", 32'(r1_seen), 32'd8);
    rd = 1'b1;
    #1;
    check("t4_full_rd_ready1", 32'(r1), 32'd0);
    cycle(1'b1);
    #1;
    check("t4_after_pop_ready1", 32'(r1), 32'd1);
    cycle(1'b0);
    v1 = 1'b0;
    for (int i = 0; i < 8; i++) cycle(1'b1);
    cycle(1'b0);

    // Wrap and concurrency: keep 3 stored while pushing and popping every cycle.
    v0 = 1'b1; a0 = 16'h3000; d0 = 8'hA0; m0 = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1);
    v0 = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1);
    cycle(1'b0);

    // Underflow is sticky and data holds; reset with 5 entries stored clears all.
    cycle(1'b1);
    check("t6_underflow", 32'(uf), 32'd1);
    cycle(1'b0);
    v0 = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b0);
    v0 = 1'b0;
    do_reset(1);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_uf_clear", 32'(uf), 32'd0);
    v1 = 1'b1; a1 = 16'hBEEF; d1 = 8'h42; m1 = 1'b1;
    cycle(1'b0);
    v1 = 1'b0;
    cycle(1'b1);
    check("t6_post_reset_data", 32'(data), 32'h01BE_EF42);
    cycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
